// File: rtl/plab4_net_router_input_ctrl_sep_if.sv
// Input-channel and request/grant bundle for one router input controller.
// The master side feeds messages and grants; the slave side is the controller.
interface plab4_net_router_input_ctrl_sep_if #(
  parameter int unsigned p_msg_nbits   = 44,
  parameter int unsigned p_num_entries = 2
);
  localparam int unsigned c_cnt_w = $clog2(p_num_entries + 1);

  logic                   in_val;
  logic                   in_rdy;
  logic [p_msg_nbits-1:0] in_msg;
  logic                   in_domain;
  logic                   reqs_domain;
  logic                   reqs_p0;
  logic                   reqs_p1;
  logic                   reqs_p2;
  logic                   grants_p0;
  logic                   grants_p1;
  logic                   grants_p2;
  logic [p_msg_nbits-1:0] out_msg;
  logic [c_cnt_w-1:0]     num_free;

  modport master (
    output in_val, in_msg, in_domain, grants_p0, grants_p1, grants_p2,
    input  in_rdy, reqs_domain, reqs_p0, reqs_p1, reqs_p2, out_msg, num_free
  );

  modport slave (
    input  in_val, in_msg, in_domain, grants_p0, grants_p1, grants_p2,
    output in_rdy, reqs_domain, reqs_p0, reqs_p1, reqs_p2, out_msg, num_free
  );
endinterface

// File: rtl/plab4_net_router_input_ctrl_sep.sv
// Router input-port control: FIFO of {domain, msg}, ring route of the head
// message onto one-hot output requests, dequeue on the matching grant.
module plab4_net_router_input_ctrl_sep #(
  parameter int unsigned p_router_id   = 0,
  parameter int unsigned p_num_routers = 4,
  parameter int unsigned p_msg_nbits   = 44,
  parameter int unsigned p_dest_msb    = 41,
  parameter int unsigned p_dest_lsb    = 40,
  parameter int unsigned p_num_entries = 2
) (
  input logic clk,
  input logic reset,
  plab4_net_router_input_ctrl_sep_if.slave bus
);

  localparam int unsigned c_ptr_w = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
  localparam int unsigned c_cnt_w = $clog2(p_num_entries + 1);
  localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(p_num_entries - 1);
  localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(p_num_entries);
  localparam logic [31:0]        c_n        = 32'(p_num_routers);
  localparam logic [31:0]        c_id       = 32'(p_router_id % p_num_routers);
  localparam logic [31:0]        c_half     = 32'(p_num_routers / 2);

  typedef logic [p_msg_nbits:0] entry_t;

  entry_t             mem [p_num_entries];
  entry_t             head_entry;
  logic [c_ptr_w-1:0] head;
  logic [c_ptr_w-1:0] tail;
  logic [c_cnt_w-1:0] count;
  logic [c_cnt_w-1:0] count_next;
  logic [c_cnt_w-1:0] free_q;
  logic               nonempty;
  logic               enq;
  logic               deq;
  logic [31:0]        dest;
  logic [31:0]        fwd;
  logic               route_p0;
  logic               route_p1;
  logic               route_p2;

  assign nonempty   = (count != '0);
  assign head_entry = mem[head];
  assign bus.in_rdy = (count != c_depth);
  assign enq        = bus.in_val && bus.in_rdy;

  // Adding c_n before subtracting keeps the eastward hop count non-negative.
  always_comb begin
    dest     = 32'(head_entry[p_dest_msb:p_dest_lsb]) % c_n;
    fwd      = (dest + c_n - c_id) % c_n;
    route_p1 = (dest == c_id);
    route_p2 = !route_p1 && (fwd <= c_half);
    route_p0 = !route_p1 && !route_p2;
  end

  assign bus.reqs_p0     = nonempty && route_p0;
  assign bus.reqs_p1     = nonempty && route_p1;
  assign bus.reqs_p2     = nonempty && route_p2;
  assign bus.reqs_domain = nonempty && head_entry[p_msg_nbits];
  assign bus.out_msg     = nonempty ? head_entry[p_msg_nbits-1:0] : '0;
  assign bus.num_free    = free_q;

  assign deq = (bus.reqs_p0 && bus.grants_p0)
            || (bus.reqs_p1 && bus.grants_p1)
            || (bus.reqs_p2 && bus.grants_p2);

  always_comb begin
    count_next = count;
    if (enq && !deq)
      count_next = count + c_cnt_w'(1);
    else if (!enq && deq)
      count_next = count - c_cnt_w'(1);
  end

  always_ff @(posedge clk) begin
    if (enq)
      mem[tail] <= {bus.in_domain, bus.in_msg};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      free_q <= c_depth;
    end else begin
      if (enq)
        tail <= (tail == c_last_ptr) ? '0 : tail + c_ptr_w'(1);
      if (deq)
        head <= (head == c_last_ptr) ? '0 : head + c_ptr_w'(1);
      count  <= count_next;
      free_q <= c_depth - count_next;
    end
  end

endmodule

// File: tb/tb_plab4_net_router_input_ctrl_sep.sv
// Bench for the router input control: vector table plus a FIFO scoreboard
// that predicts head message, domain, route, in_rdy and num_free each cycle.
module tb_plab4_net_router_input_ctrl_sep;

  localparam int unsigned N  = 4;
  localparam int unsigned ID = 1;
  localparam int unsigned W  = 44;
  localparam int unsigned D  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  plab4_net_router_input_ctrl_sep_if #(.p_msg_nbits(W), .p_num_entries(D)) bus ();

  plab4_net_router_input_ctrl_sep #(
    .p_router_id   (ID),
    .p_num_routers (N),
    .p_msg_nbits   (W),
    .p_dest_msb    (41),
    .p_dest_lsb    (40),
    .p_num_entries (D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          val;
    int unsigned dest;
    bit          dom;
    logic [2:0]  g;
    bit          rst;
    logic [2:0]  exp_reqs;
    bit          exp_rdy;
    int unsigned exp_free;
  } vec_t;

  vec_t         vecs [18];
  logic [W:0]   sb [$];
  int unsigned  total = 0;
  int unsigned  bad   = 0;

  function automatic vec_t mkv(bit val, int unsigned dest, bit dom, logic [2:0] g,
                               bit rst, logic [2:0] reqs, bit rdy, int unsigned free);
    vec_t v;
    v.val = val; v.dest = dest; v.dom = dom; v.g = g; v.rst = rst;
    v.exp_reqs = reqs; v.exp_rdy = rdy; v.exp_free = free;
    return v;
  endfunction

  function automatic logic [W-1:0] mk(int unsigned dest, logic [31:0] pay);
    logic [W-1:0] m;
    m        = '0;
    m[41:40] = dest[1:0];
    m[31:0]  = pay;
    return m;
  endfunction

  // Hop-counting route model: walk east from ID until the destination.
  function automatic logic [2:0] route_of(logic [W-1:0] m);
    int unsigned pos = ID;
    int unsigned k   = 0;
    while (pos != 32'(m[41:40])) begin
      pos = (pos + 1) % N;
      k++;
    end
    if (k == 0)          return 3'b010;
    else if (k <= N / 2) return 3'b100;
    else                 return 3'b001;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state();
    chk("in_rdy", 64'(bus.in_rdy), 64'(sb.size() < D));
    chk("num_free", 64'(bus.num_free), 64'(D - sb.size()));
    if (sb.size() == 0) begin
      chk("reqs_empty", 64'({bus.reqs_p2, bus.reqs_p1, bus.reqs_p0}), 64'd0);
      chk("out_msg_empty", 64'(bus.out_msg), 64'd0);
      chk("domain_empty", 64'(bus.reqs_domain), 64'd0);
    end else begin
      chk("reqs_route", 64'({bus.reqs_p2, bus.reqs_p1, bus.reqs_p0}),
          64'(route_of(sb[0][W-1:0])));
      chk("out_msg", 64'(bus.out_msg), 64'(sb[0][W-1:0]));
      chk("domain", 64'(bus.reqs_domain), 64'(sb[0][W]));
    end
  endtask

  task automatic cycle(bit val, logic [W-1:0] msg, bit dom, logic [2:0] g, bit rst);
    bit accept;
    bit deq_m;
    bus.in_val    = val;
    bus.in_msg    = msg;
    bus.in_domain = dom;
    bus.grants_p0 = g[0];
    bus.grants_p1 = g[1];
    bus.grants_p2 = g[2];
    reset         = rst;
    accept = val && (sb.size() < D);
    deq_m  = (sb.size() > 0) && ((g & route_of(sb[0][W-1:0])) != 3'b000);
    @(posedge clk);
    #1;
    if (rst) begin
      sb.delete();
    end else begin
      if (deq_m)  void'(sb.pop_front());
      if (accept) sb.push_back({dom, msg});
    end
    check_state();
  endtask

  initial begin
    bus.in_val = 1'b0; bus.in_msg = '0; bus.in_domain = 1'b0;
    bus.grants_p0 = 1'b0; bus.grants_p1 = 1'b0; bus.grants_p2 = 1'b0;
    reset = 1'b1;

    vecs[0]  = mkv(1, 1, 1, 3'b000, 0, 3'b010, 1, 1);
    vecs[1]  = mkv(0, 0, 0, 3'b010, 0, 3'b000, 1, 2);
    vecs[2]  = mkv(1, 2, 0, 3'b000, 0, 3'b100, 1, 1);
    vecs[3]  = mkv(0, 0, 0, 3'b100, 0, 3'b000, 1, 2);
    vecs[4]  = mkv(1, 3, 0, 3'b000, 0, 3'b100, 1, 1);
    vecs[5]  = mkv(0, 0, 0, 3'b100, 0, 3'b000, 1, 2);
    vecs[6]  = mkv(1, 0, 1, 3'b000, 0, 3'b001, 1, 1);
    vecs[7]  = mkv(0, 0, 0, 3'b001, 0, 3'b000, 1, 2);
    vecs[8]  = mkv(1, 2, 0, 3'b000, 0, 3'b100, 1, 1);
    vecs[9]  = mkv(1, 0, 1, 3'b000, 0, 3'b100, 0, 0);
    vecs[10] = mkv(1, 3, 0, 3'b000, 0, 3'b100, 0, 0);
    vecs[11] = mkv(0, 0, 0, 3'b100, 0, 3'b001, 1, 1);
    vecs[12] = mkv(0, 0, 0, 3'b001, 0, 3'b000, 1, 2);
    vecs[13] = mkv(1, 2, 1, 3'b000, 0, 3'b100, 1, 1);
    vecs[14] = mkv(0, 0, 0, 3'b011, 0, 3'b100, 1, 1);
    vecs[15] = mkv(1, 1, 0, 3'b000, 0, 3'b100, 0, 0);
    vecs[16] = mkv(0, 0, 0, 3'b111, 1, 3'b000, 1, 2);
    vecs[17] = mkv(0, 0, 0, 3'b000, 0, 3'b000, 1, 2);

    cycle(0, '0, 0, 3'b000, 1);
    cycle(0, '0, 0, 3'b111, 1);

    for (int i = 0; i < 18; i++) begin
      cycle(vecs[i].val, mk(vecs[i].dest, 32'hA000_0000 + 32'(i)), vecs[i].dom,
            vecs[i].g, vecs[i].rst);
      chk("vec_reqs", 64'({bus.reqs_p2, bus.reqs_p1, bus.reqs_p0}), 64'(vecs[i].exp_reqs));
      chk("vec_rdy", 64'(bus.in_rdy), 64'(vecs[i].exp_rdy));
      chk("vec_free", 64'(bus.num_free), 64'(vecs[i].exp_free));
    end

    // Streaming: one enqueue and one dequeue per cycle across pointer wrap.
    for (int i = 0; i < 9; i++) begin
      logic [2:0] g;
      g = (sb.size() > 0) ? route_of(sb[0][W-1:0]) : 3'b000;
      cycle(i < 8, mk($urandom_range(0, N - 1), $urandom), 1'($urandom_range(0, 1)), g, 0);
      if (i < 8)
        chk("stream_free", 64'(bus.num_free), 64'd1);
    end
    chk("stream_drained", 64'(bus.num_free), 64'(D));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/plab4_net_router_input_ctrl_sep.md
Name: plab4_net_router_input_ctrl_sep

Overview:
Input-side control for one router input port. It buffers incoming network messages and their security-domain bits in a small FIFO. For the head message it computes the output-port route on a ring and drives one-hot per-output request wires, then dequeues the head when the matching output control returns a grant. It sits between the input channel and the three output controls, on the request/grant wires those controls arbitrate.

Parameters:
p_router_id, 0, ring position of this router
p_num_routers, 4, routers on the ring (>= 2)
p_msg_nbits, 44, message width
p_dest_msb, 41, MSB of destination field in message
p_dest_lsb, 40, LSB of destination field in message
p_num_entries, 2, FIFO depth (>= 2)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_val  input  1  upstream message valid
in_rdy  output  1  block can accept a message
in_msg  input  p_msg_nbits  incoming message
in_domain  input  1  security domain of incoming message
reqs_domain  output  1  domain of head message; 0 when empty
reqs_p0  output  1  request to output 0 (west / previous router)
reqs_p1  output  1  request to output 1 (terminal)
reqs_p2  output  1  request to output 2 (east / next router)
grants_p0  input  1  grant from output 0
grants_p1  input  1  grant from output 1
grants_p2  input  1  grant from output 2
out_msg  output  p_msg_nbits  head message to crossbar; 0 when empty
num_free  output  clog2(p_num_entries+1)  free FIFO entries, for credit monitoring

Behaviour:
- Reset (synchronous): head/tail pointers cleared, count = 0. Outputs after reset: in_rdy=1, reqs_p*=0, reqs_domain=0, out_msg=0, num_free=p_num_entries.
- Enqueue: on a clk edge with in_val && in_rdy, write {in_domain, in_msg} at the tail and advance the tail with wrap-around at p_num_entries.
- in_rdy = (count != p_num_entries). There is no same-cycle full-bypass: a full FIFO deasserts in_rdy even when a grant is arriving.
- No empty-bypass: a message enqueued at edge N is first visible at the head, with a request asserted, in the cycle after edge N. Minimum in-to-grant latency is 1 cycle.
- Route, combinational from the head destination d:
  - d == p_router_id: request p1.
  - Otherwise fwd = (d - p_router_id) mod p_num_routers, computed with enough width to avoid underflow.
  - fwd <= p_num_routers/2 (integer divide): request p2. Otherwise request p0.
  - Ties on even ring sizes go east (p2).
- Requests: when count > 0, exactly one of reqs_p0..p2 is high, chosen by the route. When empty, all are low. reqs_domain and out_msg are taken from the head entry.
- Dequeue: on a clk edge where the asserted request's matching grant is high, advance the head with wrap-around. Grants on non-requested ports, or any grant while empty, are ignored: no dequeue and no state change.
- Simultaneous enqueue and dequeue:
  - Allowed whenever in_rdy=1.
  - count is unchanged.
  - With count=1, the new message becomes the head in the next cycle.
- Back-to-back: a head granted every cycle drains one message per cycle. The request for the next head is valid in the cycle immediately after the dequeue.
- Reset mid-operation: all buffered messages are discarded and requests drop in the cycle after the reset edge. Grants during reset are ignored.
- num_free = p_num_entries - count, registered alongside count.
- Domain bits travel with the message. reqs_domain never reflects a non-head entry.

Test Plan:
- Reset, then p_router_id=1, N=4. Enqueue one message with dest=1, domain=1 -> next cycle reqs_p1=1, reqs_domain=1, out_msg equals the input. Assert grants_p1 -> following cycle all reqs low, num_free=2.
- Routing sweep with id=1, N=4: dest 2 -> p2; dest 3 -> p2 (tie, fwd=2); dest 0 -> p0 (fwd=3). Exactly one req high in each case.
- Fill: enqueue 2 messages with no grants -> in_rdy=0, num_free=0. A third in_val is not accepted; grant one -> in_rdy=1 the next cycle, and the second message is at the head.
- Streaming: in_val held high and the matching grant asserted every cycle for 8 messages -> one dequeue per cycle, FIFO order preserved across pointer wrap, count stays 1.
- Spurious grant: head routed to p2, assert grants_p0 and grants_p1 -> no dequeue; the head and reqs_p2 stay stable.
- Mid-operation reset: 2 entries buffered, reset for 1 cycle -> reqs all 0, in_rdy=1, num_free=2. Grants asserted during reset cause no effect.
